// File: rtl/tmds_rx_aligner_pkg.sv
// Shared TMDS definitions: control token codes, aligner FSM states and the
// bit-offset wrap helper used by the receive aligner.
package tmds_pkg;

    localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

    localparam logic [3:0] OFFSET_MAX = 4'd9;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } aligner_state_e;

    // Advance the symbol bit offset, wrapping 9 back to 0.
    function automatic logic [3:0] next_offset(input logic [3:0] offset);
        logic [3:0] result;
        if (offset == OFFSET_MAX) begin
            result = 4'd0;
        end else begin
            result = offset + 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tmds_token_detect.sv
// Combinational TMDS control token detector. Reports whether a 10-bit
// symbol is one of the four control tokens and, if so, its {C1,C0} code.
module tmds_token_detect
    import tmds_pkg::*;
(
    input  logic [9:0] data,
    output logic       tok,
    output logic [1:0] code
);

    // Compare the symbol against each control token
    always_comb begin
        tok  = 1'b1;
        code = 2'b00;
        case (data)
            TOKEN_C00: code = 2'b00;
            TOKEN_C01: code = 2'b01;
            TOKEN_C10: code = 2'b10;
            TOKEN_C11: code = 2'b11;
            default: begin
                tok  = 1'b0;
                code = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/tmds_rx_aligner.sv
// TMDS receive word aligner for one channel. Slides a 10-bit window over
// two consecutive deserializer words, hunts for runs of control tokens to
// find the symbol boundary, and holds that offset while tokens keep showing
// up during blanking.
module tmds_rx_aligner
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS    = 16,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOSS_TIMEOUT   = 8192
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_data,
    input  logic       i_resync,
    output logic [9:0] o_data,
    output logic       o_ctrl,
    output logic [1:0] o_ctrl_code,
    output logic       o_locked,
    output logic [3:0] o_offset
);

    localparam int RUN_W  = $clog2(LOCK_TOKENS + 1);
    localparam int TMO_W  = $clog2(SEARCH_TIMEOUT + 1);
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_TOKENS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);
    localparam logic [RUN_W-1:0]  RUN_ZERO  = RUN_W'(0);
    localparam logic [TMO_W-1:0]  TMO_ZERO  = TMO_W'(0);
    localparam logic [LOSS_W-1:0] LOSS_ZERO = LOSS_W'(0);

    logic [9:0]        prev_r;
    logic [19:0]       window_s;
    logic [9:0]        aligned_s;
    logic              tok_s;
    logic [1:0]        code_s;
    logic [1:0]        ctrl_code_s;

    aligner_state_e    state_r;
    aligner_state_e    state_s;
    logic [RUN_W-1:0]  run_cnt_r;
    logic [RUN_W-1:0]  run_cnt_s;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic [TMO_W-1:0]  tmo_cnt_s;
    logic [LOSS_W-1:0] loss_cnt_r;
    logic [LOSS_W-1:0] loss_cnt_s;
    logic [3:0]        offset_s;
    logic              locked_s;

    // The previous word supplies the earlier bits, so bit 0 of the window is the oldest bit.
    assign window_s = {i_data, prev_r};

    // Extract the candidate symbol starting at the current bit offset
    always_comb begin
        aligned_s = 10'(window_s >> o_offset);
    end

    tmds_token_detect u_token_detect (
        .data (aligned_s),
        .tok  (tok_s),
        .code (code_s)
    );

    // State register: FSM state, counters, offset and lock flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= SEARCH;
            run_cnt_r  <= RUN_ZERO;
            tmo_cnt_r  <= TMO_ZERO;
            loss_cnt_r <= LOSS_ZERO;
            o_offset   <= 4'd0;
            o_locked   <= 1'b0;
        end else begin
            state_r    <= state_s;
            run_cnt_r  <= run_cnt_s;
            tmo_cnt_r  <= tmo_cnt_s;
            loss_cnt_r <= loss_cnt_s;
            o_offset   <= offset_s;
            o_locked   <= locked_s;
        end
    end

    // Next-state logic: resync beats lock, lock beats search timeout
    always_comb begin
        state_s    = state_r;
        run_cnt_s  = run_cnt_r;
        tmo_cnt_s  = tmo_cnt_r;
        loss_cnt_s = loss_cnt_r;
        offset_s   = o_offset;
        if (i_resync) begin
            state_s    = SEARCH;
            run_cnt_s  = RUN_ZERO;
            tmo_cnt_s  = TMO_ZERO;
            loss_cnt_s = LOSS_ZERO;
        end else begin
            case (state_r)
                SEARCH: begin
                    if (tok_s && (run_cnt_r == RUN_LAST)) begin
                        state_s    = LOCKED;
                        run_cnt_s  = RUN_ZERO;
                        tmo_cnt_s  = TMO_ZERO;
                        loss_cnt_s = LOSS_ZERO;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        offset_s  = next_offset(o_offset);
                        run_cnt_s = RUN_ZERO;
                        tmo_cnt_s = TMO_ZERO;
                    end else begin
                        tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                        if (tok_s) begin
                            run_cnt_s = run_cnt_r + RUN_W'(1);
                        end else begin
                            run_cnt_s = RUN_ZERO;
                        end
                    end
                end
                LOCKED: begin
                    if (tok_s) begin
                        loss_cnt_s = LOSS_ZERO;
                    end else if (loss_cnt_r == LOSS_LAST) begin
                        state_s    = SEARCH;
                        offset_s   = next_offset(o_offset);
                        run_cnt_s  = RUN_ZERO;
                        tmo_cnt_s  = TMO_ZERO;
                        loss_cnt_s = LOSS_ZERO;
                    end else begin
                        loss_cnt_s = loss_cnt_r + LOSS_W'(1);
                    end
                end
                default: begin
                    state_s    = SEARCH;
                    run_cnt_s  = RUN_ZERO;
                    tmo_cnt_s  = TMO_ZERO;
                    loss_cnt_s = LOSS_ZERO;
                end
            endcase
        end
    end

    // Output decode: lock flag follows the next state, code is zero off-token
    always_comb begin
        if (state_s == LOCKED) begin
            locked_s = 1'b1;
        end else begin
            locked_s = 1'b0;
        end
        if (tok_s) begin
            ctrl_code_s = code_s;
        end else begin
            ctrl_code_s = 2'b00;
        end
    end

    // Datapath register: previous word and the aligned symbol outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_r      <= 10'd0;
            o_data      <= 10'd0;
            o_ctrl      <= 1'b0;
            o_ctrl_code <= 2'b00;
        end else begin
            prev_r      <= i_data;
            o_data      <= aligned_s;
            o_ctrl      <= tok_s;
            o_ctrl_code <= ctrl_code_s;
        end
    end

endmodule

// File: tb/tb_tmds_rx_aligner.sv
// Self-checking bench for tmds_rx_aligner: serial bit-stream stimulus with
// a cycle-level reference model plus directed boundary checks.
module tb_tmds_rx_aligner;

    localparam int LT = 4;
    localparam int ST = 32;
    localparam int LS = 64;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;
    localparam logic [9:0] NT  = 10'b0111110000;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [9:0] i_data = 10'd0;
    logic       i_resync = 1'b0;
    logic [9:0] o_data;
    logic       o_ctrl;
    logic [1:0] o_ctrl_code;
    logic       o_locked;
    logic [3:0] o_offset;

    tmds_rx_aligner #(
        .LOCK_TOKENS    (LT),
        .SEARCH_TIMEOUT (ST),
        .LOSS_TIMEOUT   (LS)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_data      (i_data),
        .i_resync    (i_resync),
        .o_data      (o_data),
        .o_ctrl      (o_ctrl),
        .o_ctrl_code (o_ctrl_code),
        .o_locked    (o_locked),
        .o_offset    (o_offset)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    logic [9:0] toks [4];
    bit         bitq [$];
    bit         seen_c11 = 1'b0;

    // Reference model state
    logic [9:0] m_prev;
    logic [9:0] m_data;
    bit         m_ctrl;
    logic [1:0] m_code;
    bit         m_locked;
    int         m_off;
    int         m_run;
    int         m_tmo;
    int         m_loss;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 10'd0; m_data = 10'd0; m_ctrl = 1'b0; m_code = 2'b00;
        m_locked = 1'b0; m_off = 0; m_run = 0; m_tmo = 0; m_loss = 0;
    endtask

    // One clock edge of the aligner as described behaviourally.
    task automatic model_edge(input logic [9:0] d, input bit rs);
        logic [19:0] w;
        logic [9:0]  a;
        bit          tk;
        int          code;
        w = {d, m_prev};
        a = 10'(w >> m_off);
        tk = 1'b0;
        code = 0;
        for (int i = 0; i < 4; i++) begin
            if (a == toks[i]) begin
                tk = 1'b1;
                code = i;
            end
        end
        m_data = a;
        m_ctrl = tk;
        m_code = tk ? 2'(code) : 2'b00;
        m_prev = d;
        if (rs) begin
            m_locked = 1'b0; m_run = 0; m_tmo = 0; m_loss = 0;
        end else if (!m_locked) begin
            m_tmo = m_tmo + 1;
            m_run = tk ? m_run + 1 : 0;
            if (m_run == LT) begin
                m_locked = 1'b1; m_run = 0; m_tmo = 0; m_loss = 0;
            end else if (m_tmo == ST) begin
                m_off = (m_off + 1) % 10; m_run = 0; m_tmo = 0;
            end
        end else if (tk) begin
            m_loss = 0;
        end else begin
            m_loss = m_loss + 1;
            if (m_loss == LS) begin
                m_locked = 1'b0; m_off = (m_off + 1) % 10;
                m_run = 0; m_tmo = 0; m_loss = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("o_data", o_data, m_data);
        chk("o_ctrl", {9'd0, o_ctrl}, {9'd0, m_ctrl});
        chk("o_ctrl_code", {8'd0, o_ctrl_code}, {8'd0, m_code});
        chk("o_locked", {9'd0, o_locked}, {9'd0, m_locked});
        chk("o_offset", {6'd0, o_offset}, 10'(m_off));
    endtask

    task automatic step(input logic [9:0] d, input bit rs);
        i_data = d;
        i_resync = rs;
        @(posedge i_clk);
        model_edge(d, rs);
        #1;
        compare_all();
        if (o_ctrl === 1'b1 && o_ctrl_code === 2'b11) seen_c11 = 1'b1;
        i_resync = 1'b0;
    endtask

    task automatic push_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) bitq.push_back(s[i]);
    endtask

    task automatic push_junk(input int n);
        for (int i = 0; i < n; i++) bitq.push_back(bit'($urandom_range(0, 1)));
    endtask

    task automatic pop_word(output logic [9:0] w);
        for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
    endtask

    // Stream n words, topping up the serial stream with symbol s as needed.
    task automatic run_sym(input logic [9:0] s, input int n, input bit rs_first);
        logic [9:0] w;
        for (int k = 0; k < n; k++) begin
            while (bitq.size() < 10) push_sym(s);
            pop_word(w);
            step(w, rs_first && (k == 0));
        end
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        i_rst = 1'b1;
        #2;
        model_reset();
        compare_all();
        i_rst = 1'b0;
        bitq.delete();
    endtask

    initial begin
        logic [9:0] w;
        toks[0] = T00; toks[1] = T01; toks[2] = T10; toks[3] = T11;
        model_reset();
        #1;

        // 1: reset, idle zeros
        do_reset();
        for (int k = 0; k < 10; k++) step(10'd0, 1'b0);
        chk("t1_locked", {9'd0, o_locked}, 10'd0);
        chk("t1_offset", {6'd0, o_offset}, 10'd0);
        chk("t1_data", o_data, 10'd0);
        chk("t1_ctrl", {9'd0, o_ctrl}, 10'd0);

        // 2: aligned C00 stream locks on the 4th token edge
        run_sym(T00, 4, 1'b0);
        chk("t2_not_yet", {9'd0, o_locked}, 10'd0);
        run_sym(T00, 1, 1'b0);
        chk("t2_locked", {9'd0, o_locked}, 10'd1);
        run_sym(T00, 1, 1'b0);
        chk("t2_ctrl", {9'd0, o_ctrl}, 10'd1);
        chk("t2_code", {8'd0, o_ctrl_code}, 10'd0);
        chk("t2_offset", {6'd0, o_offset}, 10'd0);

        // 3: stream shifted by 3 bits, search walks to offset 3
        do_reset();
        push_junk(3);
        run_sym(T00, 200, 1'b0);
        chk("t3_locked", {9'd0, o_locked}, 10'd1);
        chk("t3_offset", {6'd0, o_offset}, 10'd3);
        chk("t3_data", o_data, T00);

        // 4: 64 non-token symbols drop lock and advance the offset
        run_sym(NT, 64, 1'b0);
        chk("t4_still_locked", {9'd0, o_locked}, 10'd1);
        run_sym(NT, 1, 1'b0);
        chk("t4_lost", {9'd0, o_locked}, 10'd0);
        chk("t4_offset", {6'd0, o_offset}, 10'd4);

        // 4b: lock at offset 9, loss wraps offset to 0
        do_reset();
        push_junk(9);
        run_sym(T00, 9 * ST + 10, 1'b0);
        chk("t4b_locked", {9'd0, o_locked}, 10'd1);
        chk("t4b_offset9", {6'd0, o_offset}, 10'd9);
        run_sym(NT, 70, 1'b0);
        chk("t4b_lost", {9'd0, o_locked}, 10'd0);
        chk("t4b_wrap", {6'd0, o_offset}, 10'd0);

        // 5: one token inside a long gap keeps the lock
        do_reset();
        push_junk(5);
        run_sym(T00, 5 * ST + 10, 1'b0);
        chk("t5_locked", {9'd0, o_locked}, 10'd1);
        chk("t5_offset", {6'd0, o_offset}, 10'd5);
        seen_c11 = 1'b0;
        run_sym(NT, 30, 1'b0);
        run_sym(T11, 1, 1'b0);
        run_sym(NT, 40, 1'b0);
        chk("t5_held", {9'd0, o_locked}, 10'd1);
        chk("t5_code11", {9'd0, seen_c11}, 10'd1);

        // 6: resync drops lock, offset held, relock after 4 tokens
        run_sym(T00, 1, 1'b1);
        chk("t6_unlocked", {9'd0, o_locked}, 10'd0);
        chk("t6_offset", {6'd0, o_offset}, 10'd5);
        run_sym(T00, 3, 1'b0);
        chk("t6_not_yet", {9'd0, o_locked}, 10'd0);
        run_sym(T00, 1, 1'b0);
        chk("t6_relock", {9'd0, o_locked}, 10'd1);

        // Random token streams at a random shift with sporadic resyncs
        do_reset();
        push_junk(int'($urandom_range(0, 9)));
        for (int k = 0; k < 400; k++) begin
            while (bitq.size() < 10) begin
                if ($urandom_range(0, 7) == 0) push_sym(10'($urandom));
                else push_sym(toks[$urandom_range(0, 3)]);
            end
            pop_word(w);
            step(w, $urandom_range(0, 59) == 0);
        end

        // Raw random words, then async reset in the middle of a search
        for (int k = 0; k < 100; k++) step(10'($urandom), 1'b0);
        step(10'($urandom), 1'b1);
        for (int k = 0; k < 40; k++) step(10'($urandom), 1'b0);
        do_reset();
        step(T00, 1'b0);
        chk("rst_prev_cleared", o_data, 10'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
